// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte-in / serial-out handshake bundle for uart_tx.
//   dt    : byte to transmit (sampled only when a request is accepted)
//   start : transmit request, level-sampled every cycle
//   TX    : serial line, idle high
//   busy  : high while a frame is in progress
//   done  : one-cycle pulse at frame end
// master = requester side, slave = the transmitter.
interface uart_tx_if;
    logic [7:0] dt;
    logic       start;
    logic       TX;
    logic       busy;
    logic       done;

    modport master (output dt, start, input TX, busy, done);
    modport slave  (input dt, start, output TX, busy, done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- 8-bit UART transmitter, LSB first, 1 start bit, 1 stop bit.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// data bit 7 (8E1). Without it the frame is 8N1.
// Ports:
//   CLOCK    : sole clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : uart_tx_if.slave (dt, start in; TX, busy, done out)
// Parameter CLKS_PER_BIT: clock cycles per serial bit (2 .. 2^20-1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic      CLOCK,
    input  logic      RESET_N,
    uart_tx_if.slave  bus
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          baud_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q;     // even parity of the byte latched at accept
`endif

    assign baud_end = (baud == BAUD_LAST);
    assign bus.TX   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_idx <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    if (bus.start) begin
                        shreg  <= bus.dt;
`ifdef UART_TX_PARITY_EN
                        par_q  <= ^bus.dt;
`endif
                        state  <= START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= DATA;
                        tx_q  <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx_q  <= par_q;
`else
                            state <= STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= STOP;
                        tx_q  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // start is deliberately not looked at here: the next
                    // request can only be taken from IDLE, after done.
                    if (baud_end) begin
                        baud   <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        tx_q   <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    baud    <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- checks uart_tx at CLKS_PER_BIT=4 and at the default 100.
// A frame-level model (bit list indexed by cycle offset) predicts TX/busy/done
// every cycle; directed sequences add hand-computed literal expectations.
module tb_uart_tx;
    localparam int N  = 4;
    localparam int NL = 100;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] A5_SLOTS = 11'h54A;
`else
    localparam int NB = 10;
    localparam logic [10:0] A5_SLOTS = 11'h74A;
`endif

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b1;
    logic       start_s = 1'b0;
    logic [7:0] dt_s = 8'h00;

    always #5 CLOCK = ~CLOCK;

    uart_tx_if bus4();
    uart_tx_if busl();

    assign bus4.dt = dt_s;
    assign bus4.start = start_s;
    assign busl.dt = dt_s;
    assign busl.start = start_s;

    uart_tx #(.CLKS_PER_BIT(N))  dut4 (.CLOCK(CLOCK), .RESET_N(RESET_N), .bus(bus4));
    uart_tx #(.CLKS_PER_BIT(NL)) dutl (.CLOCK(CLOCK), .RESET_N(RESET_N), .bus(busl));

    logic tx[2], bsy[2], dn[2];
    assign tx[0] = bus4.TX;  assign bsy[0] = bus4.busy;  assign dn[0] = bus4.done;
    assign tx[1] = busl.TX;  assign bsy[1] = busl.busy;  assign dn[1] = busl.done;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int          cpb[2] = '{N, NL};
    int          m_t[2] = '{-1, -1};          // cycles since accept, -1 = idle
    logic [10:0] m_bits[2];
    logic        m_done[2] = '{1'b0, 1'b0};

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    always @(posedge CLOCK or negedge RESET_N) begin
        for (int k = 0; k < 2; k++) begin
            if (!RESET_N) begin
                m_t[k]    <= -1;
                m_done[k] <= 1'b0;
            end else if (m_t[k] >= 0) begin
                if (m_t[k] + 1 == NB * cpb[k]) begin
                    m_t[k]    <= -1;
                    m_done[k] <= 1'b1;
                end else begin
                    m_t[k]    <= m_t[k] + 1;
                    m_done[k] <= 1'b0;
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start_s) begin
                    m_t[k]    <= 0;
                    m_bits[k] <= frame_of(dt_s);
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        for (int k = 0; k < 2; k++) begin
            logic etx;
            etx = (m_t[k] >= 0) ? m_bits[k][m_t[k] / cpb[k]] : 1'b1;
            chk(k == 0 ? "model_tx4"   : "model_txL",   32'(tx[k]),  32'(etx));
            chk(k == 0 ? "model_busy4" : "model_busyL", 32'(bsy[k]), 32'(m_t[k] >= 0));
            chk(k == 0 ? "model_done4" : "model_doneL", 32'(dn[k]),  32'(m_done[k]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle(input int k);
        int c;
        c = 0;
        while (bsy[k] && c < 3000) begin
            @(negedge CLOCK);
            c++;
        end
        chk("wait_idle_timeout", 32'(bsy[k]), 32'd0);
    endtask

    // Pulse start for one cycle, then observe DUT k cycle by cycle starting
    // at the first cycle after the accepting edge.
    task automatic send(input logic [7:0] d, input int k, output int nbusy,
                        output int done_at, output int nlow, output logic [10:0] slots);
        dt_s = d;
        start_s = 1'b1;
        @(negedge CLOCK);
        start_s = 1'b0;
        nbusy = 0; done_at = -1; nlow = 0; slots = '1;
        for (int c = 0; c < 12 * cpb[k] + 4 && done_at < 0; c++) begin
            if (bsy[k]) nbusy++;
            if (!tx[k]) nlow++;
            if (c % cpb[k] == cpb[k] / 2 && c / cpb[k] < 11) slots[c / cpb[k]] = tx[k];
            if (dn[k]) done_at = c;
            @(negedge CLOCK);
        end
    endtask

    initial begin
        int nbusy, done_at, nlow, got, ndone;
        logic [10:0] slots;

        // reset held with start=1: nothing may start
        #1 RESET_N = 1'b0;
        start_s = 1'b1;
        dt_s = 8'hFF;
        repeat (5) @(negedge CLOCK);
        chk("reset_tx", 32'(tx[0]), 32'd1);
        chk("reset_busy", 32'(bsy[0]), 32'd0);
        start_s = 1'b0;
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK);
        chk("post_reset_busy", 32'(bsy[0]), 32'd0);
        chk("post_reset_done", 32'(dn[0]), 32'd0);

        // default timing: 0x00 at 100 clocks per bit
        send(8'h00, 1, nbusy, done_at, nlow, slots);
        chk("L_low_cycles", 32'(nlow), 32'((NB - 1) * NL));
        chk("L_busy_cycles", 32'(nbusy), 32'(NB * NL));
        chk("L_done_at", 32'(done_at), 32'(NB * NL));

        // basic 0xA5 frame
        wait_idle(0);
        send(8'hA5, 0, nbusy, done_at, nlow, slots);
        chk("A5_slots", 32'(slots), 32'(A5_SLOTS));
        chk("A5_busy_cycles", 32'(nbusy), 32'(NB * N));
        chk("A5_done_at", 32'(done_at), 32'(NB * N));

        // 0x07: bit 9 is parity (1) or stop (1); bits 1..3 high, 4..8 low
        wait_idle(0);
        send(8'h07, 0, nbusy, done_at, nlow, slots);
        chk("07_slot9", 32'(slots[9]), 32'd1);
        chk("07_slots_lo", 32'(slots[8:0]), 32'h00E);

        // protection: start held, dt changed mid-frame
        wait_idle(0);
        dt_s = 8'hA5;
        start_s = 1'b1;
        @(negedge CLOCK);
        repeat (12) @(negedge CLOCK);
        dt_s = 8'h3C;
        got = 0;
        for (int c = 0; c < 200 && got == 0; c++) begin
            @(negedge CLOCK);
            if (dn[0]) got = 1;
        end
        chk("prot_done_seen", 32'(got), 32'd1);
        chk("prot_gap_tx", 32'(tx[0]), 32'd1);
        chk("prot_gap_busy", 32'(bsy[0]), 32'd0);
        @(negedge CLOCK);
        start_s = 1'b0;
        chk("prot_second_busy", 32'(bsy[0]), 32'd1);
        chk("prot_second_startbit", 32'(tx[0]), 32'd0);
        repeat (6) @(negedge CLOCK);
        chk("prot_second_bit0", 32'(tx[0]), 32'd0);   // 0x3C bit0; 0xA5 would give 1

        // abort during data bit 3
        wait_idle(0);
        dt_s = 8'hA5;
        start_s = 1'b1;
        @(negedge CLOCK);
        start_s = 1'b0;
        repeat (17) @(negedge CLOCK);
        #2 RESET_N = 1'b0;
        #1;
        chk("abort_tx", 32'(tx[0]), 32'd1);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLOCK);
            if (dn[0]) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        send(8'hA5, 0, nbusy, done_at, nlow, slots);
        chk("after_abort_slots", 32'(slots), 32'(A5_SLOTS));
        chk("after_abort_done_at", 32'(done_at), 32'(NB * N));

        wait_idle(1);
        repeat (3) @(negedge CLOCK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
